// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: phase detector state encoding, counter
// direction codes and the default error-word width.
package adpll_pkg;

    localparam int ERR_W_DEFAULT = 12;

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        REF_LEAD = 4'b0010,
        GEN_LEAD = 4'b0100,
        REPORT   = 4'b1000
    } pd_state_e;

    typedef enum logic [1:0] {
        DISABLE    = 2'd0,
        COUNT_UP   = 2'd1,
        COUNT_DOWN = 2'd2
    } count_dir_e;

endpackage

// File: rtl/edge_detect.sv
// Rising/falling edge detector for an already-synchronised level, using a
// one-flop history; reset loads the live level so no edge is seen after reset.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pos,
    output logic neg
);

    logic prev_r;

    // History flop; reset deliberately captures the current level.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r <= level;
        end else begin
            prev_r <= level;
        end
    end

    assign pos = level & ~prev_r;
    assign neg = ~level & prev_r;

endmodule

// File: rtl/phase_error_detector.sv
// Signed phase/frequency error measurement between reference and DCO edges.
// Optional lock detector enabled by defining PHASE_ERR_LOCK_DETECT_EN.
module phase_error_detector
    import adpll_pkg::*;
#(
    parameter int ERR_W    = ERR_W_DEFAULT,
    parameter int LOCK_TOL = 2,
    parameter int LOCK_CNT = 16
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    reference_synced_i,
    input  logic                    generated_synced_i,
    output logic signed [ERR_W-1:0] phase_err_o,
    output logic                    err_valid_o,
    output logic                    slip_o,
    output logic                    busy_o,
    output logic                    lock_o
);

    localparam logic signed [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};
    localparam logic signed [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic signed [ERR_W-1:0] ERR_MAX  = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic signed [ERR_W-1:0] ERR_MIN  = ERR_ZERO - ERR_MAX;

    function automatic logic signed [ERR_W-1:0] sat_step(
        input logic signed [ERR_W-1:0] value,
        input count_dir_e              dir
    );
        case (dir)
            COUNT_UP:   return (value == ERR_MAX) ? value : value + ERR_ONE;
            COUNT_DOWN: return (value == ERR_MIN) ? value : value - ERR_ONE;
            default:    return value;
        endcase
    endfunction

    logic ref_pos_s, ref_neg_s, gen_pos_s, gen_neg_s;
    pd_state_e state_r;
    logic signed [ERR_W-1:0] counter_r;
    logic signed [ERR_W-1:0] phase_err_r;
    logic err_valid_r, slip_r;
    logic rep_valid_s, rep_slip_s;
    logic signed [ERR_W-1:0] rep_err_s;

    edge_detect u_ref_edge (
        .clk   (fpga_clk_i),
        .reset (reset_i),
        .level (reference_synced_i),
        .pos   (ref_pos_s),
        .neg   (ref_neg_s)
    );

    edge_detect u_gen_edge (
        .clk   (fpga_clk_i),
        .reset (reset_i),
        .level (generated_synced_i),
        .pos   (gen_pos_s),
        .neg   (gen_neg_s)
    );

    // Decide whether this cycle closes a comparison and what it reports.
    always_comb begin
        rep_valid_s = 1'b0;
        rep_err_s   = ERR_ZERO;
        rep_slip_s  = 1'b0;
        case (state_r)
            IDLE, REPORT: begin
                if (ref_pos_s && gen_pos_s) begin
                    rep_valid_s = 1'b1;
                end else begin
                    rep_valid_s = 1'b0;
                end
            end
            REF_LEAD: begin
                if (gen_pos_s) begin
                    rep_valid_s = 1'b1;
                    rep_err_s   = counter_r;
                end else if (ref_neg_s) begin
                    rep_valid_s = 1'b1;
                    rep_err_s   = ERR_MAX;
                    rep_slip_s  = 1'b1;
                end else begin
                    rep_valid_s = 1'b0;
                end
            end
            GEN_LEAD: begin
                if (ref_pos_s) begin
                    rep_valid_s = 1'b1;
                    rep_err_s   = counter_r;
                end else if (gen_neg_s) begin
                    rep_valid_s = 1'b1;
                    rep_err_s   = ERR_MIN;
                    rep_slip_s  = 1'b1;
                end else begin
                    rep_valid_s = 1'b0;
                end
            end
            default: rep_valid_s = 1'b0;
        endcase
    end

    // Detector FSM with saturating lead/lag counter and registered report.
    // REPORT re-applies the IDLE rules so an edge seen during it starts a new run.
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state_r     <= IDLE;
            counter_r   <= ERR_ZERO;
            phase_err_r <= ERR_ZERO;
            err_valid_r <= 1'b0;
            slip_r      <= 1'b0;
        end else begin
            err_valid_r <= rep_valid_s;
            if (rep_valid_s) begin
                phase_err_r <= rep_err_s;
                slip_r      <= rep_slip_s;
            end else begin
                phase_err_r <= phase_err_r;
                slip_r      <= slip_r;
            end
            case (state_r)
                IDLE, REPORT: begin
                    if (ref_pos_s && gen_pos_s) begin
                        state_r   <= REPORT;
                        counter_r <= ERR_ZERO;
                    end else if (ref_pos_s) begin
                        state_r   <= REF_LEAD;
                        counter_r <= ERR_ONE;
                    end else if (gen_pos_s) begin
                        state_r   <= GEN_LEAD;
                        counter_r <= ERR_ZERO - ERR_ONE;
                    end else begin
                        state_r   <= IDLE;
                        counter_r <= ERR_ZERO;
                    end
                end
                REF_LEAD: begin
                    if (rep_valid_s) begin
                        state_r   <= REPORT;
                        counter_r <= ERR_ZERO;
                    end else begin
                        state_r   <= REF_LEAD;
                        counter_r <= sat_step(counter_r, COUNT_UP);
                    end
                end
                GEN_LEAD: begin
                    if (rep_valid_s) begin
                        state_r   <= REPORT;
                        counter_r <= ERR_ZERO;
                    end else begin
                        state_r   <= GEN_LEAD;
                        counter_r <= sat_step(counter_r, COUNT_DOWN);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    counter_r <= ERR_ZERO;
                end
            endcase
        end
    end

    assign phase_err_o = phase_err_r;
    assign err_valid_o = err_valid_r;
    assign slip_o      = slip_r;
    assign busy_o      = (state_r == REF_LEAD) || (state_r == GEN_LEAD);

    if (LOCK_TOL < 0 || LOCK_CNT < 1) begin : g_bad_lock_params
        $error("phase_error_detector: LOCK_TOL must be >= 0 and LOCK_CNT >= 1");
    end

`ifdef PHASE_ERR_LOCK_DETECT_EN
    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] TOL     = ERR_W'(LOCK_TOL);

    logic [RUN_W-1:0] run_r;
    logic             lock_r;
    logic [ERR_W-1:0] abs_err_s;

    assign abs_err_s = rep_err_s[ERR_W-1] ? ERR_ZERO - rep_err_s : rep_err_s;

    // Count consecutive in-tolerance reports; any other report breaks lock.
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            run_r  <= {RUN_W{1'b0}};
            lock_r <= 1'b0;
        end else if (rep_valid_s) begin
            if (!rep_slip_s && (abs_err_s <= TOL)) begin
                if (run_r != RUN_MAX) begin
                    run_r  <= run_r + RUN_ONE;
                    lock_r <= (run_r + RUN_ONE == RUN_MAX);
                end else begin
                    run_r  <= run_r;
                    lock_r <= 1'b1;
                end
            end else begin
                run_r  <= {RUN_W{1'b0}};
                lock_r <= 1'b0;
            end
        end else begin
            run_r  <= run_r;
            lock_r <= lock_r;
        end
    end

    assign lock_o = lock_r;
`else
    assign lock_o = 1'b0;
`endif

endmodule
